// File: rtl/ram_arb_pkg.sv
// ============================================================================
// ram_arb_pkg : shared types and port ids for the RAM port arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// ============================================================================
// rr_arbiter2 : two-way combinational round-robin grant selection
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter2
  import ram_arb_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last_grant,
  output logic o_grant_valid,
  output logic o_grant_id
);

  always_comb begin
    o_grant_valid = i_req0 | i_req1;
    // A tie goes to whichever port did not win last time
    if (i_req0 && i_req1) begin
      o_grant_id = ~i_last_grant;
    end else if (i_req1) begin
      o_grant_id = PORT1;
    end else begin
      o_grant_id = PORT0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram_port_arbiter.sv
// ============================================================================
// ram_port_arbiter : round-robin sharing of one 32-bit data RAM by two ports
// Rev 1.0
// ============================================================================
`default_nettype none

module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int G           = 18,
  parameter int D           = 1024,
  parameter int ALIGN_CHECK = 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          req0_i,
  input  logic          we0_i,
  input  logic [G-1:0]  addr0_i,
  input  logic [31:0]   wdata0_i,
  output logic          ack0_o,
  output logic [31:0]   rdata0_o,
  output logic          err0_o,
  input  logic          req1_i,
  input  logic          we1_i,
  input  logic [G-1:0]  addr1_i,
  input  logic [31:0]   wdata1_i,
  output logic          ack1_o,
  output logic [31:0]   rdata1_o,
  output logic          err1_o,
  output logic [G-1:0]  ram_addr_o,
  output logic [31:0]   ram_data_o,
  output logic          ram_en_o,
  input  logic [31:0]   ram_data_i,
  output logic          busy_o
);

  localparam logic [G-1:0] c_max_addr = G'(D - 4);

  arb_state_t   r_state;
  logic         r_last_grant;
  logic         r_port;
  logic         r_err;

  logic         w_grant_valid;
  logic         w_grant_id;
  logic         w_we;
  logic         w_err;
  logic [G-1:0] w_addr;
  logic [31:0]  w_wdata;

  rr_arbiter2 u_rr (
    .i_req0        (req0_i),
    .i_req1        (req1_i),
    .i_last_grant  (r_last_grant),
    .o_grant_valid (w_grant_valid),
    .o_grant_id    (w_grant_id)
  );

  // Range check on the raw address, so addr+1..3 can never wrap into legal space
  always_comb begin
    w_addr  = (w_grant_id == PORT1) ? addr1_i  : addr0_i;
    w_wdata = (w_grant_id == PORT1) ? wdata1_i : wdata0_i;
    w_we    = (w_grant_id == PORT1) ? we1_i    : we0_i;
    w_err   = (w_addr > c_max_addr) ||
              ((ALIGN_CHECK != 0) && (w_addr[1:0] != 2'b00));
  end

  assign busy_o = (r_state != IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= IDLE;
      r_last_grant <= PORT1;
      r_port       <= PORT0;
      r_err        <= 1'b0;
      ram_en_o     <= 1'b0;
      ram_addr_o   <= '0;
      ram_data_o   <= '0;
      ack0_o       <= 1'b0;
      ack1_o       <= 1'b0;
      rdata0_o     <= '0;
      rdata1_o     <= '0;
      err0_o       <= 1'b0;
      err1_o       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          ack0_o <= 1'b0;
          ack1_o <= 1'b0;
          if (w_grant_valid) begin
            r_state      <= ACCESS;
            r_port       <= w_grant_id;
            r_last_grant <= w_grant_id;
            r_err        <= w_err;
            ram_addr_o   <= w_addr;
            ram_data_o   <= w_wdata;
            ram_en_o     <= w_we & ~w_err;
          end
        end
        ACCESS: begin
          // The RAM has committed any write on the negedge; its read port shows the result
          ram_en_o <= 1'b0;
          r_state  <= RESP;
          if (r_port == PORT0) begin
            ack0_o   <= 1'b1;
            err0_o   <= r_err;
            rdata0_o <= r_err ? 32'h0 : ram_data_i;
          end else begin
            ack1_o   <= 1'b1;
            err1_o   <= r_err;
            rdata1_o <= r_err ? 32'h0 : ram_data_i;
          end
        end
        RESP: begin
          ack0_o  <= 1'b0;
          ack1_o  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          ram_en_o <= 1'b0;
          ack0_o   <= 1'b0;
          ack1_o   <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
// ============================================================================
// tb_ram_port_arbiter : directed bench with byte-addressed big-endian RAM models
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ram_port_arbiter;

  localparam int G = 18;
  localparam int D = 1024;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  // Main instance (alignment checking on)
  logic req0 = 0, we0 = 0, req1 = 0, we1 = 0;
  logic [G-1:0] addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic ack0, err0, ack1, err1, ram_en, busy;
  logic [31:0] rdata0, rdata1, ram_wdata, ram_rdata;
  logic [G-1:0] ram_addr;

  // Second instance (alignment checking off)
  logic n_req0 = 0, n_we0 = 0, n_req1 = 0, n_we1 = 0;
  logic [G-1:0] n_addr0 = '0, n_addr1 = '0;
  logic [31:0] n_wdata0 = '0, n_wdata1 = '0;
  logic n_ack0, n_err0, n_ack1, n_err1, n_ram_en, n_busy;
  logic [31:0] n_rdata0, n_rdata1, n_ram_wdata, n_ram_rdata;
  logic [G-1:0] n_ram_addr;

  ram_port_arbiter #(.G(G), .D(D), .ALIGN_CHECK(1)) dut (
    .CLK(CLK), .RST(RST),
    .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0),
    .ack0_o(ack0), .rdata0_o(rdata0), .err0_o(err0),
    .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1),
    .ack1_o(ack1), .rdata1_o(rdata1), .err1_o(err1),
    .ram_addr_o(ram_addr), .ram_data_o(ram_wdata), .ram_en_o(ram_en),
    .ram_data_i(ram_rdata), .busy_o(busy)
  );

  ram_port_arbiter #(.G(G), .D(D), .ALIGN_CHECK(0)) dut_na (
    .CLK(CLK), .RST(RST),
    .req0_i(n_req0), .we0_i(n_we0), .addr0_i(n_addr0), .wdata0_i(n_wdata0),
    .ack0_o(n_ack0), .rdata0_o(n_rdata0), .err0_o(n_err0),
    .req1_i(n_req1), .we1_i(n_we1), .addr1_i(n_addr1), .wdata1_i(n_wdata1),
    .ack1_o(n_ack1), .rdata1_o(n_rdata1), .err1_o(n_err1),
    .ram_addr_o(n_ram_addr), .ram_data_o(n_ram_wdata), .ram_en_o(n_ram_en),
    .ram_data_i(n_ram_rdata), .busy_o(n_busy)
  );

  // RAM models: byte i starts as i ^ 0xA5, writes land on negedge, reads are combinational
  logic [7:0] mem   [0:D-1];
  logic [7:0] n_mem [0:D-1];
  bit mem_ready = 1'b0;

  always @(negedge CLK) begin
    if (!mem_ready) begin
      for (int i = 0; i < D; i++) begin
        mem[i]   <= 8'(i) ^ 8'hA5;
        n_mem[i] <= 8'(i) ^ 8'hA5;
      end
      mem_ready <= 1'b1;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (ram_en && (int'(ram_addr) + k < D))
          mem[int'(ram_addr) + k] <= ram_wdata[31-8*k -: 8];
        if (n_ram_en && (int'(n_ram_addr) + k < D))
          n_mem[int'(n_ram_addr) + k] <= n_ram_wdata[31-8*k -: 8];
      end
    end
  end

  always_comb begin
    ram_rdata   = '0;
    n_ram_rdata = '0;
    for (int k = 0; k < 4; k++) begin
      if (int'(ram_addr) + k < D)   ram_rdata[31-8*k -: 8]   = mem[int'(ram_addr) + k];
      if (int'(n_ram_addr) + k < D) n_ram_rdata[31-8*k -: 8] = n_mem[int'(n_ram_addr) + k];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Wait for an ack on instance sel, then check latency, winner, data, error and RAM enables
  task automatic wait_ack(input bit sel, input string nm, input logic port, input int lat,
                          input logic [31:0] exp_rd, input logic exp_err, input int exp_en,
                          input bit drop);
    int n = 0;
    int enc = 0;
    bit got = 0;
    logic a0, a1, e;
    logic [31:0] rd;
    while (!got && n < 8) begin
      @(posedge CLK); #1;
      n++;
      if (sel ? n_ram_en : ram_en) enc++;
      a0 = sel ? n_ack0 : ack0;
      a1 = sel ? n_ack1 : ack1;
      if (a0 | a1) got = 1;
    end
    rd = (port == 1'b0) ? (sel ? n_rdata0 : rdata0) : (sel ? n_rdata1 : rdata1);
    e  = (port == 1'b0) ? (sel ? n_err0 : err0) : (sel ? n_err1 : err1);
    chk({nm, " latency"}, 32'(n), 32'(lat));
    chk({nm, " ack0"}, {31'b0, a0}, {31'b0, port == 1'b0});
    chk({nm, " ack1"}, {31'b0, a1}, {31'b0, port == 1'b1});
    chk({nm, " rdata"}, rd, exp_rd);
    chk({nm, " err"}, {31'b0, e}, {31'b0, exp_err});
    chk({nm, " ram_en cycles"}, 32'(enc), 32'(exp_en));
    chk({nm, " ram_en in ack"}, {31'b0, sel ? n_ram_en : ram_en}, 32'h0);
    if (drop) begin
      if (sel) begin
        if (port == 1'b0) n_req0 = 0; else n_req1 = 0;
      end else begin
        if (port == 1'b0) req0 = 0; else req1 = 0;
      end
    end
  endtask

  typedef struct {
    logic        port;
    logic        we;
    logic [17:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_en;
  } vec_t;

  vec_t tv [12];

  initial begin
    tv[0]  = '{1'b0, 1'b1, 18'h00010, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1};
    tv[1]  = '{1'b0, 1'b0, 18'h00010, 32'h0,        32'hDEADBEEF, 1'b0, 0};
    tv[2]  = '{1'b0, 1'b0, 18'h00100, 32'h0,        32'hA5A4A7A6, 1'b0, 0};
    tv[3]  = '{1'b1, 1'b0, 18'h003FC, 32'h0,        32'h59585B5A, 1'b0, 0};
    tv[4]  = '{1'b1, 1'b1, 18'h003FD, 32'hCAFEF00D, 32'h0,        1'b1, 0};
    tv[5]  = '{1'b1, 1'b1, 18'h00002, 32'h12345678, 32'h0,        1'b1, 0};
    tv[6]  = '{1'b1, 1'b0, 18'h00000, 32'h0,        32'hA5A4A7A6, 1'b0, 0};
    tv[7]  = '{1'b1, 1'b0, 18'h003FC, 32'h0,        32'h59585B5A, 1'b0, 0};
    tv[8]  = '{1'b1, 1'b1, 18'h003FC, 32'h0BADF00D, 32'h0BADF00D, 1'b0, 1};
    tv[9]  = '{1'b0, 1'b0, 18'h003FC, 32'h0,        32'h0BADF00D, 1'b0, 0};
    tv[10] = '{1'b0, 1'b0, 18'h00400, 32'h0,        32'h0,        1'b1, 0};
    tv[11] = '{1'b0, 1'b0, 18'h3FFFC, 32'h0,        32'h0,        1'b1, 0};

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("reset busy", {31'b0, busy}, 32'h0);
    chk("reset ram_en", {31'b0, ram_en}, 32'h0);
    chk("reset ram_addr", 32'(ram_addr), 32'h0);
    chk("reset ram_data", ram_wdata, 32'h0);
    chk("reset acks", {30'b0, ack0, ack1}, 32'h0);
    chk("reset rdata0", rdata0, 32'h0);
    chk("reset rdata1", rdata1, 32'h0);
    chk("reset errs", {30'b0, err0, err1}, 32'h0);
    RST = 0;

    // Single-port transactions
    for (int i = 0; i < 12; i++) begin
      if (tv[i].port == 1'b0) begin
        we0 = tv[i].we; addr0 = tv[i].addr; wdata0 = tv[i].wdata; req0 = 1;
      end else begin
        we1 = tv[i].we; addr1 = tv[i].addr; wdata1 = tv[i].wdata; req1 = 1;
      end
      wait_ack(0, $sformatf("vec%0d", i), tv[i].port, 2, tv[i].exp_rd, tv[i].exp_err,
               tv[i].exp_en, 1);
      @(posedge CLK); #1;
      chk($sformatf("vec%0d idle busy", i), {31'b0, busy}, 32'h0);
    end

    // Ties: last winner was port 0, so port 1 goes first, then alternation continues
    we0 = 0; addr0 = 18'h010; we1 = 0; addr1 = 18'h100;
    req0 = 1; req1 = 1;
    wait_ack(0, "tie1 first", 1'b1, 2, 32'hA5A4A7A6, 1'b0, 0, 1);
    wait_ack(0, "tie1 second", 1'b0, 3, 32'hDEADBEEF, 1'b0, 0, 1);
    @(posedge CLK); #1;
    req0 = 1; req1 = 1;
    wait_ack(0, "tie2 first", 1'b1, 2, 32'hA5A4A7A6, 1'b0, 0, 1);
    wait_ack(0, "tie2 second", 1'b0, 3, 32'hDEADBEEF, 1'b0, 0, 1);
    @(posedge CLK); #1;

    // Reset in the middle of an access
    we0 = 1; addr0 = 18'h030; wdata0 = 32'h55555555; req0 = 1;
    @(posedge CLK); #1;
    chk("rst-mid ram_en before", {31'b0, ram_en}, 32'h1);
    chk("rst-mid busy before", {31'b0, busy}, 32'h1);
    RST = 1;
    @(posedge CLK); #1;
    chk("rst-mid ram_en", {31'b0, ram_en}, 32'h0);
    chk("rst-mid busy", {31'b0, busy}, 32'h0);
    chk("rst-mid acks", {30'b0, ack0, ack1}, 32'h0);
    RST = 0;
    we0 = 0; addr0 = 18'h010; req0 = 1; req1 = 1;
    wait_ack(0, "post-rst tie first", 1'b0, 2, 32'hDEADBEEF, 1'b0, 0, 1);
    wait_ack(0, "post-rst tie second", 1'b1, 3, 32'hA5A4A7A6, 1'b0, 0, 1);
    @(posedge CLK); #1;

    // Request held past its ack becomes a fresh request
    addr0 = 18'h100; req0 = 1;
    wait_ack(0, "held first", 1'b0, 2, 32'hA5A4A7A6, 1'b0, 0, 0);
    wait_ack(0, "held regrant", 1'b0, 3, 32'hA5A4A7A6, 1'b0, 0, 1);
    @(posedge CLK); #1;

    // Unaligned access on the no-align-check build: big-endian lane check
    n_we1 = 1; n_addr1 = 18'h020; n_wdata1 = 32'h11223344; n_req1 = 1;
    wait_ack(1, "na write", 1'b1, 2, 32'h11223344, 1'b0, 1, 1);
    @(posedge CLK); #1;
    n_we0 = 0; n_addr0 = 18'h021; n_req0 = 1;
    wait_ack(1, "na read 0x021", 1'b0, 2, 32'h22334481, 1'b0, 0, 1);
    @(posedge CLK); #1;
    n_we1 = 0; n_addr1 = 18'h002; n_req1 = 1;
    wait_ack(1, "na read 0x002", 1'b1, 2, 32'hA7A6A1A0, 1'b0, 0, 1);
    @(posedge CLK); #1;
    n_we1 = 0; n_addr1 = 18'h3FD; n_req1 = 1;
    wait_ack(1, "na range 0x3FD", 1'b1, 2, 32'h0, 1'b1, 0, 1);
    @(posedge CLK); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
